// File: rtl/n64_pkg.sv
// Shared constants and state encoding for the N64 controller link receivers.
package n64_pkg;

    localparam int unsigned N64_BITS   = 32;
    localparam int unsigned SAMPLE_US  = 2;
    localparam int unsigned TIMEOUT_US = 100;
    localparam int unsigned CELL_US    = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EDGE,
        SAMPLE,
        WAIT_HIGH,
        DONE,
        ABORT
    } state_t;

endpackage

// File: rtl/n64_sync_edge.sv
// Two-flop synchronizer for the idle-high pad line with a registered falling-edge flag.
module n64_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    output logic sync,
    output logic fall
);

    logic meta;

    // fall is asserted in the same cycle that sync first reads low
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            fall <= 1'b0;
        end else begin
            meta <= data_in;
            sync <= meta;
            fall <= sync & ~meta;
        end
    end

endmodule

// File: rtl/n64_resp_rx.sv
// Receives the controller's pulse-width-coded status response after each poll and
// presents the assembled word with a one-cycle valid strobe.
module n64_resp_rx
    import n64_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 12000000,
    parameter int unsigned SAMPLE_CYC  = CLK_HZ / 1000000 * SAMPLE_US,
    parameter int unsigned TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US,
    parameter int unsigned NBITS       = N64_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             data_in,
    output logic [NBITS-1:0] buttons,
    output logic             valid,
    output logic             busy,
    output logic             timeout_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
    localparam int unsigned IW = $clog2(NBITS + 1);

    state_t           state, state_d;
    logic [TW-1:0]    timer, timer_d, timer_inc;
    logic [IW-1:0]    idx, idx_d;
    logic [NBITS-1:0] shreg, shreg_d, buttons_d;
    logic             valid_d, busy_d, timeout_d;
    logic             sync, fall;

    n64_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .sync    (sync),
        .fall    (fall)
    );

    assign timer_inc = (timer == {TW{1'b1}}) ? timer : timer + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            idx         <= '0;
            shreg       <= '0;
            buttons     <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            idx         <= idx_d;
            shreg       <= shreg_d;
            buttons     <= buttons_d;
            valid       <= valid_d;
            busy        <= busy_d;
            timeout_err <= timeout_d;
        end
    end

    // Every wait restarts the timer on entry; the sample point is counted from the detected edge
    always_comb begin
        state_d   = state;
        timer_d   = timer_inc;
        idx_d     = idx;
        shreg_d   = shreg;
        buttons_d = buttons;
        valid_d   = 1'b0;
        busy_d    = busy;
        timeout_d = 1'b0;
        case (state)
            IDLE: begin
                timer_d = '0;
                if (start) begin
                    state_d = WAIT_EDGE;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                end
            end
            WAIT_EDGE: begin
                if (fall) begin
                    state_d = SAMPLE;
                    timer_d = '0;
                end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                    state_d   = ABORT;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            SAMPLE: begin
                if (timer == TW'(SAMPLE_CYC - 1)) begin
                    shreg_d = {shreg[NBITS-2:0], sync};
                    idx_d   = idx + IW'(1);
                    state_d = WAIT_HIGH;
                    timer_d = '0;
                end
            end
            WAIT_HIGH: begin
                if (sync) begin
                    timer_d = '0;
                    if (idx == IW'(NBITS)) begin
                        state_d   = DONE;
                        buttons_d = shreg;
                        valid_d   = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        state_d = WAIT_EDGE;
                    end
                end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                    state_d   = ABORT;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                timer_d = '0;
            end
            ABORT: begin
                state_d = IDLE;
                timer_d = '0;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_n64_resp_rx.sv
// Directed bench for n64_resp_rx: full frames, timeouts, ignored starts, reset mid-frame, marginal cells.
module tb_n64_resp_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        data_in;
    logic [31:0] buttons;
    logic        valid;
    logic        busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    int          vcnt = 0;
    int          tcnt = 0;
    int          both = 0;
    logic        vbusy = 1'b1;
    logic [31:0] vword = '0;

    n64_resp_rx dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .buttons     (buttons),
        .valid       (valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            vbusy = busy;
            vword = buttons;
        end
        if (timeout_err) tcnt++;
        if (valid && timeout_err) both++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_cell(input logic b, input int lo0, input int lo1, input int pulse_at);
        int lo;
        lo = b ? lo1 : lo0;
        data_in = 1'b0;
        for (int i = 0; i < lo; i++) begin
            start = (i == pulse_at);
            tick();
        end
        start   = 1'b0;
        data_in = 1'b1;
        repeat (48 - lo) tick();
    endtask

    task automatic send_frame(input logic [31:0] w, input int n, input int lo0, input int lo1,
                              input int pulse_bit, input bit stop);
        for (int i = 0; i < n; i++)
            send_cell(w[31-i], lo0, lo1, (i == pulse_bit) ? 3 : -1);
        if (stop) begin
            data_in = 1'b0;
            repeat (12) tick();
            data_in = 1'b1;
            repeat (36) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; data_in = 1'b1;
        repeat (3) tick();
        total++; if (buttons !== 32'h0) begin bad++; $display("FAIL reset_buttons: got %h want %h", buttons, 32'h0); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
        start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_beats_start: busy got %b want 0", busy); end
        repeat (5) tick();
    endtask

    task automatic test_frame();
        int v0;
        v0 = vcnt;
        arm();
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL frame_busy: got %b want 1", busy); end
        send_frame(32'hA5C3_0F81, 32, 36, 12, -1, 1'b1);
        repeat (10) tick();
        total++; if (vcnt !== v0 + 1) begin bad++; $display("FAIL frame_valid_count: got %0d want %0d", vcnt, v0 + 1); end
        total++; if (vword !== 32'hA5C3_0F81) begin bad++; $display("FAIL frame_word: got %h want %h", vword, 32'hA5C3_0F81); end
        total++; if (vbusy !== 1'b0) begin bad++; $display("FAIL frame_busy_at_valid: got %b want 0", vbusy); end
        total++; if (buttons !== 32'hA5C3_0F81) begin bad++; $display("FAIL frame_buttons: got %h want %h", buttons, 32'hA5C3_0F81); end
    endtask

    task automatic test_idle_timeout();
        int v0, t0, first;
        v0 = vcnt; t0 = tcnt; first = 0;
        data_in = 1'b1;
        arm();
        for (int n = 1; n <= 1300; n++) begin
            tick();
            if (timeout_err && first == 0) first = n;
        end
        total++; if (first < 1198 || first > 1202) begin bad++; $display("FAIL timeout_cycle: got %0d want 1200", first); end
        total++; if (tcnt !== t0 + 1) begin bad++; $display("FAIL timeout_count: got %0d want %0d", tcnt, t0 + 1); end
        total++; if (vcnt !== v0) begin bad++; $display("FAIL timeout_no_valid: got %0d want %0d", vcnt, v0); end
        total++; if (buttons !== 32'hA5C3_0F81) begin bad++; $display("FAIL timeout_buttons_kept: got %h want %h", buttons, 32'hA5C3_0F81); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
    endtask

    task automatic test_stuck_low();
        int v0, t0;
        v0 = vcnt; t0 = tcnt;
        arm();
        send_frame(32'h5A00_0000, 4, 36, 12, -1, 1'b0);
        data_in = 1'b0;
        repeat (1300) tick();
        total++; if (tcnt !== t0 + 1) begin bad++; $display("FAIL stuck_timeout_count: got %0d want %0d", tcnt, t0 + 1); end
        total++; if (vcnt !== v0) begin bad++; $display("FAIL stuck_no_valid: got %0d want %0d", vcnt, v0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stuck_busy: got %b want 0", busy); end
        data_in = 1'b1;
        repeat (20) tick();
        arm();
        send_frame(32'hFFFF_FFFF, 32, 36, 12, -1, 1'b1);
        repeat (10) tick();
        total++; if (vcnt !== v0 + 1) begin bad++; $display("FAIL recover_valid_count: got %0d want %0d", vcnt, v0 + 1); end
        total++; if (buttons !== 32'hFFFF_FFFF) begin bad++; $display("FAIL recover_buttons: got %h want %h", buttons, 32'hFFFF_FFFF); end
    endtask

    task automatic test_ignored_starts();
        int v0;
        v0 = vcnt;
        repeat (3) begin
            data_in = 1'b0;
            repeat (30) tick();
            data_in = 1'b1;
            repeat (30) tick();
        end
        total++; if (vcnt !== v0) begin bad++; $display("FAIL idle_edges_valid: got %0d want %0d", vcnt, v0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_edges_busy: got %b want 0", busy); end
        arm();
        send_frame(32'h1234_ABCD, 32, 36, 12, 10, 1'b1);
        repeat (10) tick();
        total++; if (vcnt !== v0 + 1) begin bad++; $display("FAIL restart_valid_count: got %0d want %0d", vcnt, v0 + 1); end
        total++; if (buttons !== 32'h1234_ABCD) begin bad++; $display("FAIL restart_buttons: got %h want %h", buttons, 32'h1234_ABCD); end
    endtask

    task automatic test_reset_mid();
        int v0;
        arm();
        send_frame(32'hDEAD_BEEF, 17, 36, 12, -1, 1'b0);
        data_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (buttons !== 32'h0) begin bad++; $display("FAIL midrst_buttons: got %h want %h", buttons, 32'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", valid); end
        v0 = vcnt;
        data_in = 1'b1;
        repeat (30) tick();
        arm();
        send_frame(32'h0000_0001, 32, 36, 12, -1, 1'b1);
        repeat (10) tick();
        total++; if (vcnt !== v0 + 1) begin bad++; $display("FAIL midrst_valid_count: got %0d want %0d", vcnt, v0 + 1); end
        total++; if (buttons !== 32'h0000_0001) begin bad++; $display("FAIL midrst_buttons_after: got %h want %h", buttons, 32'h0000_0001); end
    endtask

    task automatic test_marginal();
        int v0;
        v0 = vcnt;
        arm();
        send_frame(32'h3C96_A5E1, 32, 25, 23, -1, 1'b1);
        repeat (10) tick();
        total++; if (vcnt !== v0 + 1) begin bad++; $display("FAIL marginal_valid_count: got %0d want %0d", vcnt, v0 + 1); end
        total++; if (buttons !== 32'h3C96_A5E1) begin bad++; $display("FAIL marginal_buttons: got %h want %h", buttons, 32'h3C96_A5E1); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_in = 1'b1;
        test_reset();
        test_frame();
        test_idle_timeout();
        test_stuck_low();
        test_ignored_starts();
        test_reset_mid();
        test_marginal();
        total++; if (both !== 0) begin bad++; $display("FAIL valid_and_timeout_overlap: got %0d want 0", both); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
